// File: rtl/button_press_gen.sv
// Generates clean press/gap sequences on a raw button line so a downstream
// toggle-type button follows the requested target level.
module button_press_gen #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CW           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic target,
  output logic button,
  output logic busy,
  output logic mirror,
  output logic done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CW-1:0] PRESS_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  logic [1:0]    state_reg,  state_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          button_reg, button_next;
  logic          busy_reg,   busy_next;
  logic          mirror_reg, mirror_next;
  logic          done_reg,   done_next;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    button_next = button_reg;
    busy_next   = busy_reg;
    mirror_next = mirror_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        button_next = 1'b0;
        busy_next   = 1'b0;
        // Only press when the tracked toggle level must change.
        if (target != mirror_reg) begin
          state_next  = PRESS;
          button_next = 1'b1;
          busy_next   = 1'b1;
          mirror_next = ~mirror_reg;
          count_next  = PRESS_LOAD;
        end
      end
      PRESS: begin
        button_next = 1'b1;
        busy_next   = 1'b1;
        if (count_reg != '0) begin
          count_next = count_reg - 1'b1;
        end else begin
          state_next  = GAP;
          button_next = 1'b0;
          count_next  = GAP_LOAD;
        end
      end
      GAP: begin
        button_next = 1'b0;
        busy_next   = 1'b1;
        if (count_reg != '0) begin
          count_next = count_reg - 1'b1;
        end else begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE without disturbing mirror.
        state_next  = IDLE;
        button_next = 1'b0;
        busy_next   = 1'b0;
        count_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      button_reg <= 1'b0;
      busy_reg   <= 1'b0;
      mirror_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      button_reg <= button_next;
      busy_reg   <= busy_next;
      mirror_reg <= mirror_next;
      done_reg   <= done_next;
    end
  end

  assign button = button_reg;
  assign busy   = busy_reg;
  assign mirror = mirror_reg;
  assign done   = done_reg;

endmodule
